// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central control for a 5-stage (IF, ID, EX, MEM, WB) pipeline. Tracks valid
// bits of the four pipeline registers, detects load-use and RAW hazards, and
// drives stall, bubble, flush and ALU forwarding selects. Keeps four
// saturating performance counters.
//
// Ports
//   clk, rst           clock (rising edge), synchronous active-high reset
//   enable             global run; low freezes valid bits and counters
//   id_rs/id_rt        sources of the instruction in IF/ID (+ id_use_rs/rt)
//   ex_rs/ex_rt        sources of the instruction in ID/EX
//   ex_wr/ex_mrd/ex_rd ID/EX RegWrite, MemRead, destination
//   mem_wr/mem_rd      EX/MEM RegWrite, destination
//   wb_wr/wb_rd        MEM/WB RegWrite, destination
//   redirect           taken branch/jump resolving at stage BR_STAGE
//   cnt_clr            synchronous clear of all counters
//   pc_en, ifid_en     PC and IF/ID load enables
//   bubble             zero ID/EX control bits at the next edge
//   flush[3:0]         bit i zeroes control bits of pipe reg i+1 (IF/ID..MEM/WB)
//   fwd_a, fwd_b       00 regfile, 01 EX/MEM alu_out, 10 MEM/WB wdata
//   valid[3:0]         valid bits of IF/ID..MEM/WB
//   cyc/ret/stl/fls_cnt  cycles, retired instrs, stall cycles, redirects
//
// No state machine: the only state is the valid vector and the counters.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int FWD_EN     = 1,
  parameter int BR_STAGE   = 3,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic [REG_ADDR_W-1:0] ex_rs,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  ex_wr,
  input  logic                  ex_mrd,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  mem_wr,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  wb_wr,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  redirect,
  input  logic                  cnt_clr,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  bubble,
  output logic [3:0]            flush,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [3:0]            valid,
  output logic [CNT_W-1:0]      cyc_cnt,
  output logic [CNT_W-1:0]      ret_cnt,
  output logic [CNT_W-1:0]      stl_cnt,
  output logic [CNT_W-1:0]      fls_cnt
);

  localparam bit         FWD_ON     = (FWD_EN != 0);
  // One flush bit per pipe register younger than the resolving stage.
  localparam logic [3:0] FLUSH_MASK = 4'((1 << BR_STAGE) - 1);

  logic [3:0] valid_q;
  logic [3:0] valid_next;
  logic       ex_p, mem_p, wb_p;
  logic       use_rs, use_rt;
  logic       ex_hit, mem_hit, load_use, hazard;
  logic       redir, stall;

  function automatic logic hit(input logic [REG_ADDR_W-1:0] src,
                               input logic [REG_ADDR_W-1:0] dst,
                               input logic                  producer);
    return producer && (dst != '0) && (src == dst);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // A stage only produces a result if it holds a valid instruction that writes.
  assign ex_p   = valid_q[1] & ex_wr;
  assign mem_p  = valid_q[2] & mem_wr;
  assign wb_p   = valid_q[3] & wb_wr;
  assign use_rs = id_use_rs & valid_q[0];
  assign use_rt = id_use_rt & valid_q[0];

  assign ex_hit  = (use_rs & hit(id_rs, ex_rd, ex_p))  | (use_rt & hit(id_rt, ex_rd, ex_p));
  assign mem_hit = (use_rs & hit(id_rs, mem_rd, mem_p)) | (use_rt & hit(id_rt, mem_rd, mem_p));

  // WB matches never stall: the regfile writes in the first half-cycle.
  assign load_use = ex_mrd & ex_hit;
  assign hazard   = load_use | (!FWD_ON & (ex_hit | mem_hit));

  // Redirect wins: the stalled instruction is being flushed anyway.
  assign redir = enable & redirect;
  assign stall = enable & hazard & ~redirect;

  always_comb begin
    pc_en   = enable & ~stall;
    ifid_en = enable & ~stall;
    bubble  = stall;
    flush   = redir ? FLUSH_MASK : 4'b0000;
  end

  // EX/MEM holds the younger result, so it takes precedence over MEM/WB.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (FWD_ON) begin
      if (hit(ex_rs, mem_rd, mem_p))     fwd_a = 2'b01;
      else if (hit(ex_rs, wb_rd, wb_p))  fwd_a = 2'b10;
      if (hit(ex_rt, mem_rd, mem_p))     fwd_b = 2'b01;
      else if (hit(ex_rt, wb_rd, wb_p))  fwd_b = 2'b10;
    end
  end

  always_comb begin
    valid_next = valid_q;
    if (enable) begin
      if (redir)      valid_next = {valid_q[2:0], 1'b1} & ~FLUSH_MASK;
      else if (stall) valid_next = {valid_q[2:1], 1'b0, valid_q[0]};
      else            valid_next = {valid_q[2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      cyc_cnt <= '0;
      ret_cnt <= '0;
      stl_cnt <= '0;
      fls_cnt <= '0;
    end else begin
      valid_q <= valid_next;
      if (cnt_clr) begin
        cyc_cnt <= '0;
        ret_cnt <= '0;
        stl_cnt <= '0;
        fls_cnt <= '0;
      end else if (enable) begin
        cyc_cnt <= sat_inc(cyc_cnt);
        if (valid_q[3]) ret_cnt <= sat_inc(ret_cnt);
        if (stall)      stl_cnt <= sat_inc(stl_cnt);
        if (redir)      fls_cnt <= sat_inc(fls_cnt);
      end
    end
  end

  assign valid = valid_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, enable, id_use_rs, id_use_rt, ex_wr, ex_mrd, mem_wr, wb_wr, redirect, cnt_clr;
  logic [AW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;

  logic a_pc_en, a_ifid_en, a_bubble, b_pc_en, b_ifid_en, b_bubble;
  logic [3:0] a_flush, a_valid, b_flush, b_valid;
  logic [1:0] a_fwd_a, a_fwd_b, b_fwd_a, b_fwd_b;
  logic [31:0] a_cyc, a_ret, a_stl, a_fls;
  logic [3:0]  b_cyc, b_ret, b_stl, b_fls;

  // Instance a: forwarding, branch in MEM, 32-bit counters.
  pipe_hazard_ctrl #(.REG_ADDR_W(AW), .FWD_EN(1), .BR_STAGE(3), .CNT_W(32)) u_a (
    .clk(clk), .rst(rst), .enable(enable), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_wr(ex_wr), .ex_mrd(ex_mrd), .ex_rd(ex_rd), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .wb_wr(wb_wr), .wb_rd(wb_rd), .redirect(redirect), .cnt_clr(cnt_clr),
    .pc_en(a_pc_en), .ifid_en(a_ifid_en), .bubble(a_bubble), .flush(a_flush),
    .fwd_a(a_fwd_a), .fwd_b(a_fwd_b), .valid(a_valid),
    .cyc_cnt(a_cyc), .ret_cnt(a_ret), .stl_cnt(a_stl), .fls_cnt(a_fls));

  // Instance b: no forwarding, branch in EX, 4-bit counters.
  pipe_hazard_ctrl #(.REG_ADDR_W(AW), .FWD_EN(0), .BR_STAGE(2), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .enable(enable), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_wr(ex_wr), .ex_mrd(ex_mrd), .ex_rd(ex_rd), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .wb_wr(wb_wr), .wb_rd(wb_rd), .redirect(redirect), .cnt_clr(cnt_clr),
    .pc_en(b_pc_en), .ifid_en(b_ifid_en), .bubble(b_bubble), .flush(b_flush),
    .fwd_a(b_fwd_a), .fwd_b(b_fwd_b), .valid(b_valid),
    .cyc_cnt(b_cyc), .ret_cnt(b_ret), .stl_cnt(b_stl), .fls_cnt(b_fls));

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: per instance, occupancy of the four pipe registers and
  // four counters kept as plain integers (0 cyc, 1 ret, 2 stl, 3 fls).
  bit     mv [2][4];
  longint mc [2][4];
  int     fwd_c [2] = '{1, 0};
  int     brs_c [2] = '{3, 2};
  longint cmax  [2] = '{64'hFFFF_FFFF, 64'd15};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_hit(input logic [AW-1:0] s, input logic [AW-1:0] d,
                               input bit pv, input bit pw);
    return pv && pw && (d != 0) && (s == d);
  endfunction

  function automatic bit m_haz(input int k);
    bit ex_m, mem_m;
    ex_m  = (id_use_rs && mv[k][0] && m_hit(id_rs, ex_rd, mv[k][1], ex_wr)) ||
            (id_use_rt && mv[k][0] && m_hit(id_rt, ex_rd, mv[k][1], ex_wr));
    mem_m = (id_use_rs && mv[k][0] && m_hit(id_rs, mem_rd, mv[k][2], mem_wr)) ||
            (id_use_rt && mv[k][0] && m_hit(id_rt, mem_rd, mv[k][2], mem_wr));
    return (ex_mrd && ex_m) || (fwd_c[k] == 0 && (ex_m || mem_m));
  endfunction

  function automatic bit m_stall(input int k);
    return enable && !redirect && m_haz(k);
  endfunction

  function automatic logic [1:0] m_fwd(input int k, input logic [AW-1:0] src);
    if (fwd_c[k] == 0) return 2'd0;
    if (m_hit(src, mem_rd, mv[k][2], mem_wr)) return 2'd1;
    if (m_hit(src, wb_rd, mv[k][3], wb_wr))   return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [3:0] m_flush(input int k);
    logic [3:0] f = 4'd0;
    if (enable && redirect)
      for (int i = 0; i < brs_c[k]; i++) f[i] = 1'b1;
    return f;
  endfunction

  function automatic logic [3:0] m_valid(input int k);
    return {mv[k][3], mv[k][2], mv[k][1], mv[k][0]};
  endfunction

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      string p = (k == 0) ? "a" : "b";
      bit st = m_stall(k);
      chk({p, "_pc_en"},   (k == 0) ? a_pc_en   : b_pc_en,   enable && !st);
      chk({p, "_ifid_en"}, (k == 0) ? a_ifid_en : b_ifid_en, enable && !st);
      chk({p, "_bubble"},  (k == 0) ? a_bubble  : b_bubble,  st);
      chk({p, "_flush"},   (k == 0) ? a_flush   : b_flush,   m_flush(k));
      chk({p, "_fwd_a"},   (k == 0) ? a_fwd_a   : b_fwd_a,   m_fwd(k, ex_rs));
      chk({p, "_fwd_b"},   (k == 0) ? a_fwd_b   : b_fwd_b,   m_fwd(k, ex_rt));
      chk({p, "_valid"},   (k == 0) ? a_valid   : b_valid,   m_valid(k));
      chk({p, "_cyc"},     (k == 0) ? a_cyc : 32'(b_cyc), mc[k][0]);
      chk({p, "_ret"},     (k == 0) ? a_ret : 32'(b_ret), mc[k][1]);
      chk({p, "_stl"},     (k == 0) ? a_stl : 32'(b_stl), mc[k][2]);
      chk({p, "_fls"},     (k == 0) ? a_fls : 32'(b_fls), mc[k][3]);
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      bit st = m_stall(k);
      bit rd = enable && redirect;
      bit ret_now = mv[k][3];
      bit nv [4];
      if (rst) begin
        for (int i = 0; i < 4; i++) begin mv[k][i] = 0; mc[k][i] = 0; end
      end else begin
        if (enable) begin
          if (st && !rd) begin
            nv[3] = mv[k][2]; nv[2] = mv[k][1]; nv[1] = 0; nv[0] = mv[k][0];
          end else begin
            nv[3] = mv[k][2]; nv[2] = mv[k][1]; nv[1] = mv[k][0]; nv[0] = 1;
            if (rd) for (int i = 0; i < brs_c[k]; i++) nv[i] = 0;
          end
          for (int i = 0; i < 4; i++) mv[k][i] = nv[i];
        end
        if (cnt_clr) begin
          for (int i = 0; i < 4; i++) mc[k][i] = 0;
        end else if (enable) begin
          mc[k][0] = (mc[k][0] + 1 > cmax[k]) ? cmax[k] : mc[k][0] + 1;
          if (ret_now) mc[k][1] = (mc[k][1] + 1 > cmax[k]) ? cmax[k] : mc[k][1] + 1;
          if (st)      mc[k][2] = (mc[k][2] + 1 > cmax[k]) ? cmax[k] : mc[k][2] + 1;
          if (rd)      mc[k][3] = (mc[k][3] + 1 > cmax[k]) ? cmax[k] : mc[k][3] + 1;
        end
      end
    end
  endtask

  task automatic half_a();
    @(negedge clk);
    check_all();
  endtask

  task automatic half_b();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic tick();
    half_a();
    half_b();
  endtask

  task automatic clear_ctl();
    id_use_rs = 0; id_use_rt = 0; ex_wr = 0; ex_mrd = 0; mem_wr = 0; wb_wr = 0;
    redirect = 0; cnt_clr = 0;
    id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
  endtask

  logic [31:0] s_a_stl, s_a_fls;
  logic [3:0]  s_b_stl;

  initial begin
    clear_ctl();
    rst = 1; enable = 0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) begin mv[k][i] = 0; mc[k][i] = 0; end

    // Reset, then 10 hazard-free cycles.
    @(posedge clk); #1;
    @(posedge clk); #1;
    half_a();
    chk("rst_valid", a_valid, 4'b0000);
    chk("rst_pc_en", a_pc_en, 1'b0);
    half_b();
    rst = 0; enable = 1;
    repeat (10) tick();
    half_a();
    chk("t1_valid", a_valid, 4'b1111);
    chk("t1_cyc", a_cyc, 32'd10);
    chk("t1_stl", a_stl, 32'd0);
    half_b();

    // Load-use: one stall, then EX/MEM forwarding.
    ex_mrd = 1; ex_wr = 1; ex_rd = 2; id_rs = 2; id_use_rs = 1;
    half_a();
    chk("t2_pc_en", a_pc_en, 1'b0);
    chk("t2_ifid_en", a_ifid_en, 1'b0);
    chk("t2_bubble", a_bubble, 1'b1);
    s_a_stl = a_stl;
    half_b();
    clear_ctl(); mem_wr = 1; mem_rd = 2; ex_rs = 2;
    half_a();
    chk("t2_fwd_a", a_fwd_a, 2'b01);
    chk("t2_pc_en_after", a_pc_en, 1'b1);
    chk("t2_stl", a_stl, s_a_stl + 32'd1);
    half_b();

    // Forwarding priority and $0.
    clear_ctl();
    repeat (3) tick();
    mem_wr = 1; mem_rd = 5; wb_wr = 1; wb_rd = 5; ex_rt = 5;
    half_a();
    chk("t3_fwd_b_mem", a_fwd_b, 2'b01);
    chk("t3_nofwd_b", b_fwd_b, 2'b00);
    half_b();
    mem_wr = 0;
    half_a();
    chk("t3_fwd_b_wb", a_fwd_b, 2'b10);
    half_b();
    mem_wr = 1; mem_rd = 0; wb_rd = 0; ex_rt = 0;
    half_a();
    chk("t3_fwd_b_zero", a_fwd_b, 2'b00);
    half_b();

    // Redirect coincident with load-use.
    clear_ctl();
    ex_mrd = 1; ex_wr = 1; ex_rd = 7; id_rs = 7; id_use_rs = 1; redirect = 1;
    half_a();
    chk("t4_flush_a", a_flush, 4'b0111);
    chk("t4_flush_b", b_flush, 4'b0011);
    chk("t4_pc_en", a_pc_en, 1'b1);
    chk("t4_bubble", a_bubble, 1'b0);
    s_a_stl = a_stl; s_a_fls = a_fls;
    half_b();
    clear_ctl();
    half_a();
    chk("t4_valid_low", a_valid & 4'b0111, 4'b0000);
    chk("t4_fls", a_fls, s_a_fls + 32'd1);
    chk("t4_stl", a_stl, s_a_stl);
    half_b();

    // No forwarding: RAW stalls while producer sits in EX and MEM.
    repeat (4) tick();
    ex_wr = 1; ex_rd = 3; id_rt = 3; id_use_rt = 1;
    half_a();
    chk("t5_bubble1_b", b_bubble, 1'b1);
    chk("t5_bubble1_a", a_bubble, 1'b0);
    s_b_stl = b_stl;
    half_b();
    ex_wr = 0; mem_wr = 1; mem_rd = 3;
    half_a();
    chk("t5_bubble2_b", b_bubble, 1'b1);
    half_b();
    mem_wr = 0; wb_wr = 1; wb_rd = 3;
    half_a();
    chk("t5_bubble3_b", b_bubble, 1'b0);
    chk("t5_stl_b", 32'(b_stl), (s_b_stl + 2 > 15) ? 32'd15 : 32'(s_b_stl) + 32'd2);
    half_b();

    // Saturation, clear, reset during a stall.
    clear_ctl();
    half_a();
    chk("t6_cyc_sat", b_cyc, 4'd15);
    half_b();
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    half_a();
    chk("t6_clr_b", b_cyc, 4'd0);
    chk("t6_clr_a", a_cyc, 32'd0);
    half_b();
    repeat (3) tick();
    ex_mrd = 1; ex_wr = 1; ex_rd = 4; id_rs = 4; id_use_rs = 1;
    half_a();
    chk("t6_stall", a_bubble, 1'b1);
    rst = 1;
    half_b();
    rst = 0; clear_ctl();
    half_a();
    chk("t6_rst_valid_a", a_valid, 4'b0000);
    chk("t6_rst_valid_b", b_valid, 4'b0000);
    chk("t6_rst_stl", a_stl, 32'd0);
    half_b();

    // Randomized traffic against the model.
    repeat (600) begin
      rst       = ($urandom_range(59) == 0);
      cnt_clr   = ($urandom_range(39) == 0);
      enable    = ($urandom_range(9) != 0);
      redirect  = ($urandom_range(7) == 0);
      id_use_rs = $urandom_range(1); id_use_rt = $urandom_range(1);
      ex_wr     = $urandom_range(1); ex_mrd    = $urandom_range(1);
      mem_wr    = $urandom_range(1); wb_wr     = $urandom_range(1);
      id_rs  = AW'($urandom_range(3)); id_rt  = AW'($urandom_range(3));
      ex_rs  = AW'($urandom_range(3)); ex_rt  = AW'($urandom_range(3));
      ex_rd  = AW'($urandom_range(3)); mem_rd = AW'($urandom_range(3));
      wb_rd  = AW'($urandom_range(3));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
